// File: rtl/fc_layer_sequencer_if.sv
// Buffer-read and result-stream bundle for fc_layer_sequencer.
// master: the sequencer (drives strobes, addresses and results).
// slave : the buffers and result consumer.
interface fc_layer_sequencer_if #(
    parameter int INPUT_SIZE  = 512,
    parameter int OUTPUT_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32
);
    localparam int AW  = $clog2(INPUT_SIZE);
    localparam int WAW = $clog2(INPUT_SIZE * OUTPUT_SIZE);
    localparam int NW  = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

    logic                         act_rd;
    logic [AW-1:0]                act_addr;
    logic signed [DATA_WIDTH-1:0] act_data;

    logic                         wgt_rd;
    logic [WAW-1:0]               wgt_addr;
    logic signed [DATA_WIDTH-1:0] wgt_data;

    logic                         bias_rd;
    logic [NW-1:0]                bias_addr;
    logic signed [ACC_WIDTH-1:0]  bias_data;

    logic                         out_valid;
    logic [NW-1:0]                out_idx;
    logic signed [DATA_WIDTH-1:0] out_data;

    modport master (
        output act_rd, act_addr, input act_data,
        output wgt_rd, wgt_addr, input wgt_data,
        output bias_rd, bias_addr, input bias_data,
        output out_valid, out_idx, out_data
    );

    modport slave (
        input act_rd, act_addr, output act_data,
        input wgt_rd, wgt_addr, output wgt_data,
        input bias_rd, bias_addr, output bias_data,
        input out_valid, out_idx, out_data
    );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Time-multiplexed fully connected layer controller.
// Per neuron: fetch bias, stream INPUT_SIZE activation/weight pairs through one
// MAC, drain the last product, then emit one saturated result.
module fc_layer_sequencer #(
    parameter int INPUT_SIZE  = 512,
    parameter int OUTPUT_SIZE = 3,
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 32,
    parameter int RELU_EN     = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    fc_layer_sequencer_if.master bus
);
    localparam int AW  = $clog2(INPUT_SIZE);
    localparam int WAW = $clog2(INPUT_SIZE * OUTPUT_SIZE);
    localparam int NW  = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
    localparam int PW  = 2 * DATA_WIDTH;

    localparam logic [AW-1:0] J_LAST = AW'(INPUT_SIZE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(OUTPUT_SIZE - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                       state_q, state_d;
    logic [NW-1:0]                n_q, n_d;
    logic [AW-1:0]                j_q, j_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         act_rd_q, act_rd_d;
    logic                         wgt_rd_q, wgt_rd_d;
    logic                         bias_rd_q, bias_rd_d;
    logic [AW-1:0]                act_addr_q, act_addr_d;
    logic [WAW-1:0]               wgt_addr_q, wgt_addr_d;
    logic [NW-1:0]                bias_addr_q, bias_addr_d;
    logic                         out_valid_q, out_valid_d;
    logic [NW-1:0]                out_idx_q, out_idx_d;
    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic signed [PW-1:0]         prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;

    // Clamp the accumulator into the output range, optionally zeroing negatives.
    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] a);
        if (RELU_EN != 0 && a < 0) begin
            return '0;
        end else if (a > SAT_MAX) begin
            return DATA_WIDTH'(SAT_MAX);
        end else if (a < SAT_MIN) begin
            return DATA_WIDTH'(SAT_MIN);
        end
        return a[DATA_WIDTH-1:0];
    endfunction

    // Signed product of the pair read last cycle, sign-extended to accumulator width.
    always_comb begin
        prod     = PW'(bus.act_data) * PW'(bus.wgt_data);
        prod_ext = ACC_WIDTH'(prod);
    end

    // Next-state, counters, accumulator and registered-output values.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        j_d         = j_q;
        acc_d       = acc_q;
        act_rd_d    = 1'b0;
        wgt_rd_d    = 1'b0;
        bias_rd_d   = 1'b0;
        act_addr_d  = act_addr_q;
        wgt_addr_d  = wgt_addr_q;
        bias_addr_d = bias_addr_q;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d     = S_BIAS;
                    n_d         = '0;
                    j_d         = '0;
                    bias_rd_d   = 1'b1;
                    bias_addr_d = '0;
                end
            end
            S_BIAS: begin
                state_d    = S_MAC;
                j_d        = '0;
                act_rd_d   = 1'b1;
                wgt_rd_d   = 1'b1;
                act_addr_d = '0;
                wgt_addr_d = WAW'(int'(n_q) * INPUT_SIZE);
            end
            S_MAC: begin
                // j_q is the index issued this cycle; data returning now belongs to
                // j_q-1, or is the bias when j_q is 0.
                acc_d = (j_q == '0) ? bus.bias_data : acc_q + prod_ext;
                if (j_q == J_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    j_d        = j_q + 1'b1;
                    act_rd_d   = 1'b1;
                    wgt_rd_d   = 1'b1;
                    act_addr_d = j_q + 1'b1;
                    wgt_addr_d = wgt_addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                acc_d   = acc_q + prod_ext;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                out_valid_d = 1'b1;
                out_idx_d   = n_q;
                out_data_d  = sat(acc_q);
                if (n_q == N_LAST) begin
                    state_d = S_DONE;
                end else begin
                    n_d         = n_q + 1'b1;
                    state_d     = S_BIAS;
                    bias_rd_d   = 1'b1;
                    bias_addr_d = n_q + 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides every state-specific action, including WRITE and DONE pulses.
        if (abort && state_q != S_IDLE) begin
            state_d     = S_IDLE;
            n_d         = '0;
            j_d         = '0;
            act_rd_d    = 1'b0;
            wgt_rd_d    = 1'b0;
            bias_rd_d   = 1'b0;
            out_valid_d = 1'b0;
            out_idx_d   = out_idx_q;
            out_data_d  = out_data_q;
            done_d      = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            act_rd_q    <= 1'b0;
            wgt_rd_q    <= 1'b0;
            bias_rd_q   <= 1'b0;
            act_addr_q  <= '0;
            wgt_addr_q  <= '0;
            bias_addr_q <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            j_q         <= j_d;
            acc_q       <= acc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            act_rd_q    <= act_rd_d;
            wgt_rd_q    <= wgt_rd_d;
            bias_rd_q   <= bias_rd_d;
            act_addr_q  <= act_addr_d;
            wgt_addr_q  <= wgt_addr_d;
            bias_addr_q <= bias_addr_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.act_rd    = act_rd_q;
    assign bus.act_addr  = act_addr_q;
    assign bus.wgt_rd    = wgt_rd_q;
    assign bus.wgt_addr  = wgt_addr_q;
    assign bus.bias_rd   = bias_rd_q;
    assign bus.bias_addr = bias_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench: two sequencers (ReLU on / off) share stimulus and buffer contents.
module tb_fc_layer_sequencer;
    localparam int IS = 4;
    localparam int OS = 2;
    localparam int DW = 8;
    localparam int AW = 32;

    typedef struct {
        int dut;
        int idx;
        int data;
        int lat;
    } exp_t;

    logic clk   = 1'b0;
    logic rstn  = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy0, done0, busy1, done1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    exp_t sbq[$];
    exp_t dq[$];
    exp_t e;

    logic signed [DW-1:0] act_mem  [IS];
    logic signed [DW-1:0] wgt_mem  [IS*OS];
    logic signed [AW-1:0] bias_mem [OS];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fc_layer_sequencer_if #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus0 ();
    fc_layer_sequencer_if #(.INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus1 ();

    fc_layer_sequencer #(
        .INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .RELU_EN(1)
    ) u_dut_relu (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .busy(busy0), .done(done0), .bus(bus0)
    );

    fc_layer_sequencer #(
        .INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .RELU_EN(0)
    ) u_dut_lin (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .busy(busy1), .done(done1), .bus(bus1)
    );

    // One-cycle-latency buffer models
    always @(posedge clk) begin
        if (bus0.act_rd)  bus0.act_data  <= act_mem[bus0.act_addr];
        if (bus0.wgt_rd)  bus0.wgt_data  <= wgt_mem[bus0.wgt_addr];
        if (bus0.bias_rd) bus0.bias_data <= bias_mem[bus0.bias_addr];
        if (bus1.act_rd)  bus1.act_data  <= act_mem[bus1.act_addr];
        if (bus1.wgt_rd)  bus1.wgt_data  <= wgt_mem[bus1.wgt_addr];
        if (bus1.bias_rd) bus1.bias_data <= bias_mem[bus1.bias_addr];
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model(input int n, input bit relu);
        int acc;
        acc = int'(bias_mem[n]);
        for (int j = 0; j < IS; j++) acc += int'(act_mem[j]) * int'(wgt_mem[n*IS+j]);
        if (relu && acc < 0) return 0;
        if (acc > 127) return 127;
        if (acc < -128) return -128;
        return acc;
    endfunction

    task automatic push_expected();
        exp_t x;
        for (int n = 0; n < OS; n++) begin
            for (int d = 0; d < 2; d++) begin
                x.dut = d; x.idx = n; x.data = model(n, d == 0);
                x.lat = IS + 4 + n * (IS + 3);
                sbq.push_back(x);
            end
        end
        for (int d = 0; d < 2; d++) begin
            x.dut = d; x.idx = 0; x.data = 0; x.lat = OS * (IS + 3) + 2;
            dq.push_back(x);
        end
    endtask

    // Output monitor
    logic ov [2];
    logic dn [2];
    logic bz [2];
    int   oi [2];
    int   od [2];
    always_comb begin
        ov[0] = bus0.out_valid; ov[1] = bus1.out_valid;
        dn[0] = done0;          dn[1] = done1;
        bz[0] = busy0;          bz[1] = busy1;
        oi[0] = int'(bus0.out_idx);  oi[1] = int'(bus1.out_idx);
        od[0] = int'(bus0.out_data); od[1] = int'(bus1.out_data);
    end

    always @(negedge clk) begin
        if (rstn) begin
            for (int d = 0; d < 2; d++) begin
                if (ov[d]) begin
                    check_eq("out_expected", sbq.size() > 0, 1);
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        check_eq("out_dut", d, e.dut);
                        check_eq("out_idx", oi[d], e.idx);
                        check_eq("out_data", od[d], e.data);
                        check_eq("out_latency", cyc - t0, e.lat);
                    end
                end
                if (dn[d]) begin
                    check_eq("done_expected", dq.size() > 0, 1);
                    check_eq("busy_low_at_done", bz[d], 0);
                    if (dq.size() > 0) begin
                        e = dq.pop_front();
                        check_eq("done_dut", d, e.dut);
                        check_eq("done_latency", cyc - t0, e.lat);
                    end
                end
            end
        end
    end

    task automatic start_pass(input bit expect_out);
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        if (expect_out) push_expected();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_pass(input string tag);
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_timeout"}, n < 200, 1);
        repeat (3) @(negedge clk);
        check_eq({tag, "_outs_pending"}, sbq.size(), 0);
        check_eq({tag, "_done_pending"}, dq.size(), 0);
    endtask

    task automatic load_case1();
        for (int j = 0; j < IS; j++) begin
            act_mem[j]      = DW'(j + 1);
            wgt_mem[j]      = 8'sd1;
            wgt_mem[IS + j] = 8'sd0;
        end
        wgt_mem[IS]         = 8'sd2;
        wgt_mem[IS + IS - 1] = 8'sd1;
        bias_mem[0] = 32'sd5;
        bias_mem[1] = -32'sd3;
    endtask

    task automatic load_uniform(input int a, input int w0, input int w1, input int b0, input int b1);
        for (int j = 0; j < IS; j++) begin
            act_mem[j]      = DW'(a);
            wgt_mem[j]      = DW'(w0);
            wgt_mem[IS + j] = DW'(w1);
        end
        bias_mem[0] = AW'(b0);
        bias_mem[1] = AW'(b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        load_case1();
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", busy0 | busy1, 0);
        check_eq("reset_done", done0 | done1, 0);
        check_eq("reset_strobes", bus0.act_rd | bus0.wgt_rd | bus0.bias_rd | bus1.act_rd, 0);
        check_eq("reset_out_valid", bus0.out_valid | bus1.out_valid, 0);
        check_eq("reset_out_data", bus0.out_data, 0);
        rstn = 1'b1;
        @(negedge clk);

        // start and abort together in IDLE: stays idle
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check_eq("start_abort_idle", busy0 | busy1, 0);

        // Case 1: reference pass with cycle timing
        start_pass(1);
        check_eq("busy_after_start", busy0, 1);
        finish_pass("case1");

        // Case 2: positive and negative saturation
        load_uniform(127, 127, -127, 0, 0);
        start_pass(1);
        finish_pass("case2");

        // Case 3: ReLU clamps a small negative sum
        load_uniform(1, -1, 1, 0, -3);
        start_pass(1);
        finish_pass("case3");

        // Case 4: start held high through the pass: no restart
        load_case1();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        push_expected();
        repeat (13) @(negedge clk);
        start = 1'b0;
        finish_pass("case4");
        repeat (20) @(negedge clk);
        check_eq("case4_no_restart", busy0 | busy1, 0);

        // Case 5: abort in DRAIN drops the neuron and the pass
        start_pass(0);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", busy0 | busy1, 0);
        check_eq("abort_strobes", bus0.act_rd | bus0.wgt_rd | bus0.bias_rd, 0);
        repeat (20) @(negedge clk);
        check_eq("abort_stays_idle", busy0 | busy1, 0);
        start_pass(1);
        finish_pass("case5_rerun");

        // Case 6: asynchronous reset mid-MAC
        start_pass(1);
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_eq("async_rst_busy", busy0 | busy1, 0);
        check_eq("async_rst_act_rd", bus0.act_rd | bus1.act_rd, 0);
        check_eq("async_rst_act_addr", bus0.act_addr, 0);
        check_eq("async_rst_wgt_addr", bus1.wgt_addr, 0);
        sbq.delete();
        dq.delete();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("post_rst_strobes",
                     bus0.act_rd | bus0.wgt_rd | bus0.bias_rd | bus1.act_rd | bus1.wgt_rd | bus1.bias_rd, 0);
        end
        start_pass(1);
        finish_pass("case6_rerun");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
